// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed image over 8N1 serial, writes it into RAM as an
// AHB-Lite write-only master, and releases the core from reset once the checksum matches.
module uart_boot_loader #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned AHBW      = 32,
  parameter logic [31:0] LOAD_BASE = 32'h00002000,
  parameter int unsigned MAX_WORDS = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            UartRx,
  input  logic            HREADY,
  output logic [31:0]     HADDR,
  output logic [1:0]      HTRANS,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [AHBW-1:0] HWDATA,
  output logic            CoreReset,
  output logic            LoadDone,
  output logic            LoadErr
);

  localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;
  localparam logic [15:0] DivLast  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HalfLast = 16'(BAUD_DIV / 2 - 1);
  localparam logic [1:0]  TrIdle   = 2'b00;
  localparam logic [1:0]  TrNonseq = 2'b10;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  typedef enum logic [3:0] {
    StSync, StLen0, StLen1, StData, StAddr, StWdata, StChk, StDone, StErr
  } state_e;

  // Receiver state
  rx_state_e   r_rx_state;
  logic        r_rx_meta, r_rx_sync;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_byte;
  logic        r_byte_valid;
  logic        r_framing_err;

  // Loader state
  state_e          r_state;
  logic [15:0]     r_len;
  logic [15:0]     r_idx;
  logic [1:0]      r_byte_k;
  logic [7:0]      r_sum;
  logic [AHBW-1:0] r_buf;
  logic [31:0]     r_haddr;
  logic [1:0]      r_htrans;
  logic            r_hwrite;
  logic [AHBW-1:0] r_hwdata;
  logic            r_core_reset;
  logic            r_load_done;
  logic            r_load_err;

  logic [15:0] w_len;
  logic [15:0] w_idx_next;
  logic [31:0] w_addr;
  logic        w_fe_abort;

  assign HADDR     = r_haddr;
  assign HTRANS    = r_htrans;
  assign HWRITE    = r_hwrite;
  assign HSIZE     = 3'b010;
  assign HWDATA    = r_hwdata;
  assign CoreReset = r_core_reset;
  assign LoadDone  = r_load_done;
  assign LoadErr   = r_load_err;

  assign w_len      = {r_rx_byte, r_len[7:0]};
  assign w_idx_next = r_idx + 16'd1;
  assign w_addr     = LOAD_BASE + {14'd0, r_idx, 2'b00};
  assign w_fe_abort = r_framing_err &&
                      !(r_state inside {StSync, StDone, StErr});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta     <= 1'b1;
      r_rx_sync     <= 1'b1;
      r_rx_state    <= RxIdle;
      r_baud_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_rx_byte     <= '0;
      r_byte_valid  <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_rx_meta     <= UartRx;
      r_rx_sync     <= r_rx_meta;
      r_byte_valid  <= 1'b0;
      r_framing_err <= 1'b0;
      unique case (r_rx_state)
        RxIdle: begin
          r_baud_cnt <= '0;
          if (!r_rx_sync) r_rx_state <= RxStart;
        end
        RxStart: begin
          // Mid-start-bit recheck rejects short low glitches
          if (r_baud_cnt == HalfLast) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_rx_state <= r_rx_sync ? RxIdle : RxData;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        RxData: begin
          if (r_baud_cnt == DivLast) begin
            r_baud_cnt <= '0;
            r_shift    <= {r_rx_sync, r_shift[7:1]};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_rx_state <= RxStop;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        RxStop: begin
          if (r_baud_cnt == DivLast) begin
            r_baud_cnt <= '0;
            r_rx_state <= RxIdle;
            if (r_rx_sync) begin
              r_byte_valid <= 1'b1;
              r_rx_byte    <= r_shift;
            end else begin
              r_framing_err <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        default: r_rx_state <= RxIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StSync;
      r_len        <= '0;
      r_idx        <= '0;
      r_byte_k     <= '0;
      r_sum        <= '0;
      r_buf        <= '0;
      r_haddr      <= '0;
      r_htrans     <= TrIdle;
      r_hwrite     <= 1'b0;
      r_hwdata     <= '0;
      r_core_reset <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StSync, StErr: begin
          if (r_byte_valid && r_rx_byte == 8'hA5) begin
            r_state    <= StLen0;
            r_idx      <= '0;
            r_sum      <= '0;
            r_load_err <= 1'b0;
          end
        end
        StLen0: begin
          if (r_byte_valid) begin
            r_len[7:0] <= r_rx_byte;
            r_state    <= StLen1;
          end
        end
        StLen1: begin
          if (r_byte_valid) begin
            r_len    <= w_len;
            r_byte_k <= '0;
            if (w_len == 16'd0 || w_len > 16'(MAX_WORDS)) begin
              r_state    <= StErr;
              r_load_err <= 1'b1;
            end else begin
              r_state <= StData;
            end
          end
        end
        StData: begin
          if (r_byte_valid) begin
            r_buf[{r_byte_k, 3'b000} +: 8] <= r_rx_byte;
            r_sum    <= r_sum + r_rx_byte;
            r_byte_k <= r_byte_k + 2'd1;
            if (r_byte_k == 2'd3) begin
              r_state  <= StAddr;
              r_htrans <= TrNonseq;
              r_hwrite <= 1'b1;
              r_haddr  <= w_addr;
            end
          end
        end
        StAddr: begin
          if (HREADY) begin
            r_state  <= StWdata;
            r_htrans <= TrIdle;
            r_hwrite <= 1'b0;
            r_hwdata <= r_buf;
          end
        end
        StWdata: begin
          if (HREADY) begin
            r_idx   <= w_idx_next;
            r_state <= (w_idx_next == r_len) ? StChk : StData;
          end
        end
        StChk: begin
          if (r_byte_valid) begin
            if (r_rx_byte == r_sum) begin
              r_state     <= StDone;
              r_load_done <= 1'b1;
            end else begin
              r_state    <= StErr;
              r_load_err <= 1'b1;
            end
          end
        end
        StDone: begin
          r_load_done  <= 1'b1;
          r_core_reset <= 1'b0;
        end
        default: r_state <= StSync;
      endcase
      // A corrupted byte anywhere inside a frame kills the frame
      if (w_fe_abort) begin
        r_state    <= StErr;
        r_load_err <= 1'b1;
        r_htrans   <= TrIdle;
        r_hwrite   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed vector table, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_uart_boot_loader;

  localparam int unsigned CLK_HZ = 1600000;
  localparam int unsigned BAUD   = 100000;
  localparam int          DIV    = 16;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef logic [7:0] bq_t[$];
  typedef wr_t        wq_t[$];

  typedef struct {
    int          ws;
    logic [15:0] len;
    logic [7:0]  chk;
    int          bad;
    bit          gl;
    bit          e_done;
    bit          e_err;
    int          e_nwr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        UartRx;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        CoreReset;
  logic        LoadDone;
  logic        LoadErr;

  int n_checks = 0;
  int n_pass   = 0;

  wq_t         wr_q;
  int          ws_n = 0;
  int          ws_cnt = 0;
  bit          dphase = 0;
  bit          aw_prev = 0;
  bit          dw_prev = 0;
  logic [31:0] held_addr, held_data, pend_addr;

  uart_boot_loader #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .AHBW     (32),
    .LOAD_BASE(32'h00002000),
    .MAX_WORDS(128)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .UartRx   (UartRx),
    .HREADY   (HREADY),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HWDATA   (HWDATA),
    .CoreReset(CoreReset),
    .LoadDone (LoadDone),
    .LoadErr  (LoadErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Slave model: inserts ws_n wait states per phase, records completed writes
  always @(posedge clk) begin : mon
    bit in_addr, in_data;
    #1;
    if (reset) begin
      dphase  = 0;
      aw_prev = 0;
      dw_prev = 0;
      ws_cnt  = 0;
      HREADY  = 1'b1;
    end else begin
      in_data = dphase;
      in_addr = (HTRANS == 2'b10);
      if ((in_addr || in_data) && ws_cnt < ws_n) begin
        HREADY = 1'b0;
        ws_cnt++;
      end else begin
        HREADY = 1'b1;
        ws_cnt = 0;
      end
      if (aw_prev) begin
        check("addr_hold_htrans", 32'(HTRANS), 32'd2);
        check("addr_hold_haddr", HADDR, held_addr);
      end
      if (dw_prev) check("data_hold_hwdata", HWDATA, held_data);
      if (in_addr && HREADY) begin
        check("hwrite", 32'(HWRITE), 32'd1);
        check("hsize", 32'(HSIZE), 32'd2);
        pend_addr = HADDR;
      end
      if (in_data && HREADY) wr_q.push_back('{pend_addr, HWDATA});
      aw_prev   = in_addr && !HREADY;
      held_addr = HADDR;
      dw_prev   = in_data && !HREADY;
      held_data = HWDATA;
      dphase    = (in_data && !HREADY) || (in_addr && HREADY);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    UartRx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      UartRx = b[i];
      tick(DIV);
    end
    UartRx = !bad;
    tick(DIV);
    UartRx = 1'b1;
    tick(8);
  endtask

  task automatic glitch();
    UartRx = 1'b0;
    tick(6);
    UartRx = 1'b1;
    tick(10);
  endtask

  task automatic send_frame(input bq_t f, input int bad, input bit gl);
    if (gl) glitch();
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i], i == bad);
      if (gl && i == 2) glitch();
    end
    tick(3 * DIV);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(2);
    wr_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_htrans"}, 32'(HTRANS), 32'd0);
    check({tag, "_haddr"}, HADDR, 32'd0);
    check({tag, "_hwrite"}, 32'(HWRITE), 32'd0);
    check({tag, "_hwdata"}, HWDATA, 32'd0);
    check({tag, "_hsize"}, 32'(HSIZE), 32'd2);
    check({tag, "_corereset"}, 32'(CoreReset), 32'd1);
    check({tag, "_loaddone"}, 32'(LoadDone), 32'd0);
    check({tag, "_loaderr"}, 32'(LoadErr), 32'd0);
  endtask

  task automatic check_status(input string tag, input bit done, input bit err);
    check({tag, "_loaddone"}, 32'(LoadDone), 32'(done));
    check({tag, "_loaderr"}, 32'(LoadErr), 32'(err));
    check({tag, "_corereset"}, 32'(CoreReset), 32'(!done));
  endtask

  task automatic check_writes(input string tag, input wq_t exp);
    check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wr_q.size(); i++) begin
      check({tag, "_addr"}, wr_q[i].addr, exp[i].addr);
      check({tag, "_data"}, wr_q[i].data, exp[i].data);
    end
  endtask

  // Frame-level model: find the sync byte, apply the length rules, then the payload words
  // and the mod-256 checksum; a byte with a bad stop bit truncates the frame.
  function automatic void model(input bq_t f, input int bad, output wq_t exp,
                                output bit done, output bit err);
    int          i;
    int          n;
    int          p;
    int          len;
    logic [7:0]  sum;
    exp  = {};
    done = 0;
    err  = 0;
    sum  = 8'd0;
    i    = 0;
    while (i < f.size() && f[i] != 8'hA5) i++;
    if (i >= f.size()) return;
    n = (bad > i) ? bad : f.size();
    if (i + 2 >= n) begin
      err = (bad > i);
      return;
    end
    len = int'({f[i+2], f[i+1]});
    if (len == 0 || len > 128) begin
      err = 1;
      return;
    end
    p = i + 3;
    for (int k = 0; k < 4 * len && p + k < n; k++) sum += f[p+k];
    for (int w = 0; w < len && p + 4 * w + 3 < n; w++)
      exp.push_back('{32'h2000 + 32'(4 * w),
                      {f[p+4*w+3], f[p+4*w+2], f[p+4*w+1], f[p+4*w]}});
    if (p + 4 * len >= n) begin
      err = 1;
      return;
    end
    done = (f[p+4*len] == sum);
    err  = !done;
  endfunction

  bq_t  frm;
  wq_t  exp2;
  wq_t  expq;
  vec_t vecs[7];
  bit   m_done, m_err;

  initial begin
    reset  = 1'b1;
    UartRx = 1'b1;
    HREADY = 1'b1;
    exp2   = '{'{32'h2000, 32'h44332211}, '{32'h2004, 32'h88776655}};

    vecs[0] = '{0, 16'd2,   8'h64, -1, 1'b0, 1'b1, 1'b0, 2};
    vecs[1] = '{3, 16'd2,   8'h64, -1, 1'b0, 1'b1, 1'b0, 2};
    vecs[2] = '{0, 16'd2,   8'h65, -1, 1'b0, 1'b0, 1'b1, 2};
    vecs[3] = '{0, 16'd129, 8'h00, -1, 1'b0, 1'b0, 1'b1, 0};
    vecs[4] = '{0, 16'd0,   8'h00, -1, 1'b0, 1'b0, 1'b1, 0};
    vecs[5] = '{0, 16'd2,   8'h64,  4, 1'b0, 1'b0, 1'b1, 0};
    vecs[6] = '{1, 16'd2,   8'h64, -1, 1'b1, 1'b1, 1'b0, 2};

    tick(4);
    check_reset_vals("por");
    reset = 1'b0;
    tick(2);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      ws_n = vecs[v].ws;
      frm  = {8'hA5, vecs[v].len[7:0], vecs[v].len[15:8]};
      if (vecs[v].len == 16'd2)
        frm = {frm, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, vecs[v].chk};
      send_frame(frm, vecs[v].bad, vecs[v].gl);
      expq = {};
      for (int k = 0; k < vecs[v].e_nwr; k++) expq.push_back(exp2[k]);
      check_writes($sformatf("vec%0d", v), expq);
      check_status($sformatf("vec%0d", v), vecs[v].e_done, vecs[v].e_err);
    end

    // Bad checksum then a correct frame without an intervening reset
    do_reset();
    ws_n = 0;
    frm  = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
             8'h55, 8'h66, 8'h77, 8'h88, 8'h65};
    send_frame(frm, -1, 1'b0);
    check_status("badchk", 1'b0, 1'b1);
    wr_q.delete();
    frm[11] = 8'h64;
    send_frame(frm, -1, 1'b0);
    check_writes("retry", exp2);
    check_status("retry", 1'b1, 1'b0);

    // Reset in the middle of the second word, then a clean load
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(frm[i], 1'b0);
    tick(DIV);
    reset = 1'b1;
    tick(3);
    check_reset_vals("midrst");
    reset = 1'b0;
    tick(2);
    wr_q.delete();
    send_frame(frm, -1, 1'b0);
    check_writes("postrst", exp2);
    check_status("postrst", 1'b1, 1'b0);

    // Randomized frames against the model
    for (int r = 0; r < 6; r++) begin
      int          len;
      int          junk;
      int          bad;
      logic [7:0]  sum;
      logic [7:0]  b;
      do_reset();
      ws_n = $urandom_range(0, 2);
      len  = $urandom_range(1, 6);
      junk = $urandom_range(0, 2);
      frm  = {};
      sum  = 8'd0;
      for (int j = 0; j < junk; j++) begin
        b = 8'($urandom);
        frm.push_back((b == 8'hA5) ? 8'h00 : b);
      end
      frm.push_back(8'hA5);
      frm.push_back(8'(len));
      frm.push_back(8'h00);
      for (int j = 0; j < 4 * len; j++) begin
        b = 8'($urandom);
        frm.push_back(b);
        sum += b;
      end
      if ($urandom_range(0, 3) == 0) sum += 8'($urandom_range(1, 255));
      frm.push_back(sum);
      bad = ($urandom_range(0, 3) == 0) ? junk + 3 + $urandom_range(0, 4 * len) : -1;
      if (bad >= 0)
        for (int j = bad + 1; j < frm.size(); j++) if (frm[j] == 8'hA5) frm[j] = 8'h5A;
      model(frm, bad, expq, m_done, m_err);
      send_frame(frm, bad, 1'b0);
      check_writes($sformatf("rnd%0d", r), expq);
      check_status($sformatf("rnd%0d", r), m_done, m_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
